// File: rtl/div_pkg.sv
// ============================================================================
// div_pkg: shared types and constants for the restoring divider.
// Rev 1.0
// ============================================================================
`default_nettype none

package div_pkg;

  localparam int N_DEF = 3;

  typedef enum logic [2:0] {
    REPOSO   = 3'd0,
    CARGA    = 3'd1,
    DESPLAZA = 3'd2,
    RESTA    = 3'd3,
    AJUSTE   = 3'd4,
    FIN      = 3'd5
  } estado_t;

  // ceil(log2(n+1)): enough bits to hold the iteration count n itself
  function automatic int cnt_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < (n + 1)) w++;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/camino_datos_div.sv
// ============================================================================
// camino_datos_div: A/Q/M registers, shared add/sub and iteration counter.
// Rev 1.0
// ============================================================================
`default_nettype none

module camino_datos_div
  import div_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         CargaA_i,
  input  logic         CargaQ_i,
  input  logic         CargaM_i,
  input  logic         desplaza_i,
  input  logic         resta_i,
  input  logic         restaura_i,
  input  logic [N-1:0] dividendo_i,
  input  logic [N-1:0] divisor_i,
  output logic [N-1:0] q_sig_o,
  output logic [N-1:0] resto_sig_o,
  output logic         ultima_o
);

  localparam int CW = cnt_w(N);

  logic [N:0]    a_q, a_d;
  logic [N-1:0]  q_q, q_d;
  logic [N:0]    m_q, m_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N:0]    w_suma;
  logic [N:0]    w_a_rest;
  logic [N-1:0]  w_q_ajust;

  // One adder serves both the trial subtraction and the restore
  assign w_suma   = resta_i ? (a_q - m_q) : (a_q + m_q);
  assign w_a_rest = a_q[N] ? w_suma : a_q;

  always_comb begin
    w_q_ajust    = q_q;
    w_q_ajust[0] = ~a_q[N];
  end

  assign q_sig_o     = w_q_ajust;
  assign resto_sig_o = w_a_rest[N-1:0];
  assign ultima_o    = (cnt_q == CW'(1));

  always_comb begin
    a_d   = a_q;
    q_d   = q_q;
    m_d   = m_q;
    cnt_d = cnt_q;
    if (CargaA_i) a_d = '0;
    if (CargaQ_i) begin
      q_d   = dividendo_i;
      cnt_d = CW'(N);
    end
    if (CargaM_i) m_d = {1'b0, divisor_i};
    if (desplaza_i) begin
      a_d = {a_q[N-1:0], q_q[N-1]};
      q_d = q_q << 1;
    end
    if (resta_i) a_d = w_suma;
    if (restaura_i) begin
      a_d   = w_a_rest;
      q_d   = w_q_ajust;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q   <= '0;
      q_q   <= '0;
      m_q   <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      q_q   <= q_d;
      m_q   <= m_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/divisor_restaurador.sv
// ============================================================================
// divisor_restaurador: sequential unsigned restoring divider (FSM + outputs).
// Optional macro DIVISOR_DIV_CERO_EN adds div_cero and a divide-by-zero shortcut.
// Rev 1.0
// ============================================================================
`default_nettype none

module divisor_restaurador
  import div_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inicio,
  input  logic [N-1:0] dividendo,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] cociente,
  output logic [N-1:0] resto,
`ifdef DIVISOR_DIV_CERO_EN
  output logic         div_cero,
`endif
  output logic         Fin
);

  estado_t state_q, state_d;

  logic w_carga_a, w_carga_q, w_carga_m;
  logic w_desplaza, w_resta, w_restaura;
  logic w_carga_salida;
  logic w_ultima;
  logic [N-1:0] w_q_sig, w_resto_sig;

  logic [N-1:0] cociente_q, cociente_d;
  logic [N-1:0] resto_q, resto_d;

  camino_datos_div #(.N(N)) u_camino (
    .clk         (clk),
    .reset       (reset),
    .CargaA_i    (w_carga_a),
    .CargaQ_i    (w_carga_q),
    .CargaM_i    (w_carga_m),
    .desplaza_i  (w_desplaza),
    .resta_i     (w_resta),
    .restaura_i  (w_restaura),
    .dividendo_i (dividendo),
    .divisor_i   (divisor),
    .q_sig_o     (w_q_sig),
    .resto_sig_o (w_resto_sig),
    .ultima_o    (w_ultima)
  );

  always_comb begin
    state_d        = state_q;
    w_carga_a      = 1'b0;
    w_carga_q      = 1'b0;
    w_carga_m      = 1'b0;
    w_desplaza     = 1'b0;
    w_resta        = 1'b0;
    w_restaura     = 1'b0;
    w_carga_salida = 1'b0;
    case (state_q)
      REPOSO: if (inicio) state_d = CARGA;
      CARGA: begin
        w_carga_a = 1'b1;
        w_carga_q = 1'b1;
        w_carga_m = 1'b1;
        state_d   = DESPLAZA;
`ifdef DIVISOR_DIV_CERO_EN
        if (divisor == '0) state_d = FIN;
`endif
      end
      DESPLAZA: begin
        w_desplaza = 1'b1;
        state_d    = RESTA;
      end
      RESTA: begin
        w_resta = 1'b1;
        state_d = AJUSTE;
      end
      AJUSTE: begin
        w_restaura = 1'b1;
        if (w_ultima) begin
          state_d        = FIN;
          w_carga_salida = 1'b1;
        end else begin
          state_d = DESPLAZA;
        end
      end
      FIN: if (inicio) state_d = CARGA;
      default: state_d = REPOSO;
    endcase
  end

  // Results move only when entering FIN, so old values stay visible meanwhile
  always_comb begin
    cociente_d = cociente_q;
    resto_d    = resto_q;
    if (w_carga_salida) begin
      cociente_d = w_q_sig;
      resto_d    = w_resto_sig;
    end
`ifdef DIVISOR_DIV_CERO_EN
    if (state_q == CARGA && divisor == '0) begin
      cociente_d = '1;
      resto_d    = dividendo;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= REPOSO;
      cociente_q <= '0;
      resto_q    <= '0;
    end else begin
      state_q    <= state_d;
      cociente_q <= cociente_d;
      resto_q    <= resto_d;
    end
  end

`ifdef DIVISOR_DIV_CERO_EN
  logic div_cero_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cero_q <= 1'b0;
    end else if (state_q == CARGA) begin
      div_cero_q <= (divisor == '0);
    end
  end

  assign div_cero = div_cero_q;
`endif

  assign cociente = cociente_q;
  assign resto    = resto_q;
  assign Fin      = (state_q == FIN);

endmodule

`default_nettype wire

// File: tb/tb_divisor_restaurador.sv
// ============================================================================
// tb_divisor_restaurador: directed self-checking bench for divisor_restaurador.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_divisor_restaurador;

  logic       clk;
  logic       reset;
  logic       inicio;
  logic [2:0] dividendo;
  logic [2:0] divisor;
  logic [2:0] cociente;
  logic [2:0] resto;
  logic       Fin;
`ifdef DIVISOR_DIV_CERO_EN
  logic       div_cero;
`endif

  int total = 0;
  int bad   = 0;

  divisor_restaurador #(.N(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .inicio    (inicio),
    .dividendo (dividendo),
    .divisor   (divisor),
    .cociente  (cociente),
    .resto     (resto),
`ifdef DIVISOR_DIV_CERO_EN
    .div_cero  (div_cero),
`endif
    .Fin       (Fin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a division and count edges until Fin (edge sampling inicio = 1)
  task automatic run_div(input logic [2:0] a, input logic [2:0] b, input bit hold,
                         output int edges);
    logic [2:0] pq, pr;
    int unstable;
    pq        = cociente;
    pr        = resto;
    unstable  = 0;
    dividendo = a;
    divisor   = b;
    inicio    = 1'b1;
    tick();
    edges = 1;
    if (!hold) inicio = 1'b0;
    while (!Fin && edges < 40) begin
      if (cociente !== pq || resto !== pr) unstable++;
      tick();
      edges++;
    end
    check("outputs_stable_during_op", unstable, 0);
  endtask

  initial begin
    int e;
    reset     = 1'b0;
    inicio    = 1'b0;
    dividendo = '0;
    divisor   = '0;

    repeat (2) tick();
    check("rst_cociente", cociente, 0);
    check("rst_resto", resto, 0);
    check("rst_fin", Fin, 0);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_all_zero", {cociente, resto, Fin}, 0);
    end

    run_div(3'd7, 3'd2, 1'b0, e);
    check("7/2_latency", e, 11);
    check("7/2_cociente", cociente, 3);
    check("7/2_resto", resto, 1);

    run_div(3'd6, 3'd3, 1'b1, e);
    check("6/3_latency", e, 11);
    check("6/3_cociente", cociente, 2);
    check("6/3_resto", resto, 0);
    run_div(3'd5, 3'd7, 1'b1, e);
    check("5/7_latency", e, 11);
    check("5/7_cociente", cociente, 0);
    check("5/7_resto", resto, 5);
    run_div(3'd0, 3'd5, 1'b1, e);
    check("0/5_latency", e, 11);
    check("0/5_cociente", cociente, 0);
    check("0/5_resto", resto, 0);
    inicio = 1'b0;
    tick();
    check("fin_held", Fin, 1);

    run_div(3'd4, 3'd0, 1'b0, e);
`ifdef DIVISOR_DIV_CERO_EN
    check("4/0_latency", e, 2);
    check("4/0_div_cero", div_cero, 1);
`else
    check("4/0_latency", e, 11);
`endif
    check("4/0_cociente", cociente, 7);
    check("4/0_resto", resto, 4);

    // inicio pulse while in RESTA must be ignored
    dividendo = 3'd7;
    divisor   = 3'd2;
    inicio    = 1'b1;
    tick();
    inicio = 1'b0;
    tick();
    tick();
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
    e = 4;
    while (!Fin && e < 40) begin
      tick();
      e++;
    end
    check("ignore_latency", e, 11);
    check("ignore_cociente", cociente, 3);
    check("ignore_resto", resto, 1);
`ifdef DIVISOR_DIV_CERO_EN
    check("div_cero_cleared", div_cero, 0);
`endif
    repeat (5) tick();
    check("ignore_no_restart", Fin, 1);

    // asynchronous reset in the middle of DESPLAZA
    dividendo = 3'd7;
    divisor   = 3'd2;
    inicio    = 1'b1;
    tick();
    inicio = 1'b0;
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_cociente", cociente, 0);
    check("async_rst_resto", resto, 0);
    check("async_rst_fin", Fin, 0);
    #2;
    reset = 1'b1;
    repeat (15) tick();
    check("no_restart_after_rst", Fin, 0);

    run_div(3'd6, 3'd4, 1'b0, e);
    check("6/4_latency", e, 11);
    check("6/4_cociente", cociente, 1);
    check("6/4_resto", resto, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
